serial_rx: RTL and testbench
============================

SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 3200, clock cycles per bit (31250 baud MIDI at 100 MHz); legal range 16..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame, LSB first; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked: 1 or 2.
REQ-005 SHALL have port clk, input, 1 bit, single clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port rx, input, 1 bit, asynchronous serial line, idle high.
REQ-008 SHALL have port rx_byte, output, DATA_BITS bits, received data word.
REQ-009 SHALL have port rx_byte_valid, output, 1 bit, rx_byte and the error flags are valid.
REQ-010 SHALL have port rx_ready, input, 1 bit, consumer accepts the word when high together with rx_byte_valid.
REQ-011 SHALL have port frame_err, output, 1 bit, a stop bit was sampled low for the presented word.
REQ-012 SHALL have port parity_err, output, 1 bit, parity mismatch for the presented word; tied 0 when PARITY=0.
REQ-013 SHALL have port overrun, output, 1 bit, one-cycle pulse when a completed frame is dropped.

Function
REQ-014 SHALL pass rx through a 2-flop synchroniser (reset value 1) before any use.
REQ-015 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; the bit counter SHALL be $clog2(CLKS_PER_BIT) wide.
REQ-016 IDLE: on a synchronised 1->0 transition, SHALL clear the bit counter and enter START.
REQ-017 START: at count CLKS_PER_BIT/2, SHALL enter DATA if the sample is low; otherwise SHALL treat it as a glitch and return to IDLE with no output.
REQ-018 Each bit SHALL be sampled as the majority of 3 synchronised samples at counts CLKS_PER_BIT/2-1, /2 and /2+1 of that bit period.
REQ-019 DATA SHALL shift in DATA_BITS bits LSB first, then go to PARITY if PARITY!=0, else to STOP.
REQ-020 PARITY SHALL compute odd/even parity over the data bits plus the parity bit; the mismatch is stored as the parity error.
REQ-021 STOP SHALL check STOP_BITS stop bits; any low stop sample SHALL set the frame error; a break (all-zero data, stop low) SHALL be reported as a frame error.
REQ-022 At the mid-sample of the last stop bit, the FSM SHALL return to IDLE so that a start edge arriving in the second half of the stop bit is caught.
REQ-023 The word SHALL be loaded into a 1-deep output register, with rx_byte_valid high on the cycle after the last stop mid-sample.
REQ-024 rx_byte, frame_err and parity_err SHALL stay stable while rx_byte_valid=1 and rx_ready=0.
REQ-025 rx_byte_valid SHALL clear on the cycle after the rx_valid&&rx_ready handshake, unless a new word loads on the same cycle.
REQ-026 If a frame completes while the register holds an unaccepted word, the new frame SHALL be dropped, the old word kept, and overrun pulsed for 1 cycle.
REQ-027 If a handshake and a frame completion coincide, the new word SHALL load, rx_byte_valid SHALL stay 1, and overrun SHALL stay 0.

Reset
REQ-028 On rst=0, immediately (asynchronously) the FSM SHALL go to IDLE, the counter SHALL clear, the synchroniser SHALL go to 1, rx_byte SHALL be 0 and rx_byte_valid, frame_err, parity_err and overrun SHALL be 0.
REQ-029 Reset mid-frame SHALL discard the partial frame; after release, reception SHALL resume only on a fresh falling edge.

Structure
REQ-030 Parity mode encodings and FSM state encodings SHALL reside in a shared package serial_pkg.
REQ-031 The 2-flop synchroniser SHALL be the sole sub-module, sync_2ff.

Verification
REQ-032 8N1 with defaults, byte 0x55, rx_ready=1 -> rx_byte=0x55 with rx_byte_valid high for 1 cycle ~30400 cycles after the start edge, and both error flags 0.
REQ-033 Bytes 0x12 then 0xFA back-to-back with rx_ready=0 -> 0x12 held and an overrun pulse at the end of 0xFA; then rx_ready=1 -> 0x12 accepted and rx_byte_valid drops.
REQ-034 PARITY=2, byte 0x03 sent with a wrong parity bit of 1 -> parity_err=1 and rx_byte=0x03.
REQ-035 Stop bit driven low for 0xFA -> frame_err=1; 1000-cycle low glitch on an idle line -> no rx_byte_valid.
REQ-036 rst asserted in the middle of bit 4 of 0x55, then released -> all outputs 0; the next byte 0xA5 received correctly.
REQ-037 DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=16, byte 0x41 -> rx_byte=0x41; second stop bit low -> frame_err=1.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: parity-mode and FSM-state encodings shared by the serial receiver.
package serial_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous input; resets to 1 so an
// idle serial line never looks like a start edge coming out of reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ff_q <= 2'b11;
        else      ff_q <= {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/serial_rx.sv
// serial_rx: async serial receiver with 3-sample majority voting, parity/stop
// checking and a 1-deep ready/valid output register with overrun reporting.
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 3200,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_byte_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, byte_q, byte_d;
    logic                 s1_q, s1_d, s2_q, s2_d, prev_q, skip_q, skip_d;
    logic                 ferr_q, ferr_d, perr_q, perr_d;
    logic                 vld_q, vld_d, fe_q, fe_d, pe_q, pe_d, ovr_q, ovr_d;
    logic                 rx_s, maj, commit, done, hs;

    sync_2ff u_sync (.clk(clk), .rst(rst), .d_i(rx), .q_o(rx_s));

    assign maj    = maj3(s1_q, s2_q, rx_s);
    // skip_q masks the mid-sample of the start bit's second half after DATA is entered early
    assign commit = (cnt_q == HALF + 1'b1) && !skip_q;
    assign hs     = vld_q && rx_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        s1_d    = (cnt_q == HALF - 1'b1) ? rx_s : s1_q;
        s2_d    = (cnt_q == HALF) ? rx_s : s2_q;
        skip_d  = (cnt_q == LAST) ? 1'b0 : skip_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_s) begin
                    state_d = S_START;
                    ferr_d  = 1'b0;
                    perr_d  = 1'b0;
                end
            end
            S_START: if (cnt_q == HALF) begin
                state_d = rx_s ? S_IDLE : S_DATA;
                skip_d  = 1'b1;
                idx_d   = '0;
            end
            S_DATA: if (commit) begin
                shift_d = {maj, shift_q[DATA_BITS-1:1]};
                idx_d   = idx_q + 1'b1;
                if (idx_q == 4'(DATA_BITS - 1)) begin
                    idx_d   = '0;
                    state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (commit) begin
                perr_d  = (PARITY == PAR_EVEN) ? ^{shift_q, maj} : ~^{shift_q, maj};
                state_d = S_STOP;
            end
            S_STOP: if (commit) begin
                ferr_d = ferr_q | ~maj;
                idx_d  = idx_q + 1'b1;
                if (idx_q == 4'(STOP_BITS - 1)) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        vld_d  = vld_q && !hs;
        byte_d = byte_q;
        fe_d   = fe_q;
        pe_d   = pe_q;
        ovr_d  = done && vld_q && !hs;
        if (done && (!vld_q || hs)) begin
            vld_d  = 1'b1;
            byte_d = shift_q;
            fe_d   = ferr_d;
            pe_d   = perr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            prev_q  <= 1'b1;
            skip_q  <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            byte_q  <= '0;
            vld_q   <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            prev_q  <= rx_s;
            skip_q  <= skip_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            byte_q  <= byte_d;
            vld_q   <= vld_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_byte       = byte_q;
    assign rx_byte_valid = vld_q;
    assign frame_err     = fe_q;
    assign parity_err    = (PARITY != PAR_NONE) && pe_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: scoreboard bench driving four receiver configurations
// (default 8N1, fast 8N1, 8E1, 7N2) and checking every presented word.
module tb_serial_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rx, rdy, vld, ovr, fe, pe;
    logic [7:0] ba, bb, bc;
    logic [6:0] bd;
    logic [8:0] rbyte [4];

    logic [10:0] exp_q [4][$];
    int ovr_cnt [4] = '{0, 0, 0, 0};
    int vld_cnt [4] = '{0, 0, 0, 0};
    int exp_ovr [4] = '{0, 0, 0, 0};
    int n_chk = 0, n_bad = 0;
    int cyc = 0, t0_a = 0, lat_a = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_rx u_a (.clk(clk), .rst(rst), .rx(rx[0]), .rx_byte(ba), .rx_byte_valid(vld[0]),
                   .rx_ready(rdy[0]), .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ovr[0]));
    serial_rx #(.CLKS_PER_BIT(16)) u_b (.clk(clk), .rst(rst), .rx(rx[1]), .rx_byte(bb),
                   .rx_byte_valid(vld[1]), .rx_ready(rdy[1]), .frame_err(fe[1]),
                   .parity_err(pe[1]), .overrun(ovr[1]));
    serial_rx #(.CLKS_PER_BIT(16), .PARITY(2)) u_c (.clk(clk), .rst(rst), .rx(rx[2]),
                   .rx_byte(bc), .rx_byte_valid(vld[2]), .rx_ready(rdy[2]), .frame_err(fe[2]),
                   .parity_err(pe[2]), .overrun(ovr[2]));
    serial_rx #(.CLKS_PER_BIT(16), .DATA_BITS(7), .STOP_BITS(2)) u_d (.clk(clk), .rst(rst),
                   .rx(rx[3]), .rx_byte(bd), .rx_byte_valid(vld[3]), .rx_ready(rdy[3]),
                   .frame_err(fe[3]), .parity_err(pe[3]), .overrun(ovr[3]));

    assign rbyte[0] = {1'b0, ba};
    assign rbyte[1] = {1'b0, bb};
    assign rbyte[2] = {1'b0, bc};
    assign rbyte[3] = {2'b0, bd};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; stop[i] is the level of stop bit i. push=0 marks a frame expected to be dropped.
    task automatic send(input int d, input int clks, input int nbits, input logic [8:0] data,
                        input int par, input logic par_bad, input int nstop,
                        input logic [1:0] stop, input logic push);
        logic x = 1'b0;
        logic f = 1'b0;
        for (int i = 0; i < nstop; i++) if (!stop[i]) f = 1'b1;
        if (push) exp_q[d].push_back({f, (par != 0) && par_bad, data});
        rx[d] = 1'b0;
        wait_clk(clks);
        for (int i = 0; i < nbits; i++) begin
            rx[d] = data[i];
            x ^= data[i];
            wait_clk(clks);
        end
        if (par != 0) begin
            rx[d] = ((par == 2) ? x : ~x) ^ par_bad;
            wait_clk(clks);
        end
        for (int i = 0; i < nstop; i++) begin
            rx[d] = stop[i];
            wait_clk(clks);
        end
        rx[d] = 1'b1;
        wait_clk(2);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (ovr[d]) ovr_cnt[d]++;
            if (vld[d]) vld_cnt[d]++;
            if (d == 0 && vld[0] && lat_a < 0) lat_a = cyc - t0_a;
            if (vld[d] && rdy[d]) begin
                if (exp_q[d].size() == 0) check($sformatf("d%0d_spurious", d), 1, 0);
                else begin
                    logic [10:0] e;
                    e = exp_q[d].pop_front();
                    check($sformatf("d%0d_byte", d), rbyte[d], e[8:0]);
                    check($sformatf("d%0d_frame_err", d), fe[d], e[10]);
                    check($sformatf("d%0d_parity_err", d), pe[d], e[9]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        rx  = '1;
        rdy = '1;
        wait_clk(3);
        for (int d = 0; d < 4; d++)
            check($sformatf("d%0d_reset_out", d), {vld[d], ovr[d], fe[d], pe[d], rbyte[d]}, 0);
        rst = 1'b1;
        wait_clk(5);

        t0_a = cyc;
        send(0, 3200, 8, 9'h55, 0, 0, 1, 2'b11, 1);
        wait_clk(100);
        rx[0] = 1'b0;
        wait_clk(1000);
        rx[0] = 1'b1;
        wait_clk(4000);
        check("a_latency_in_window", (lat_a >= 30400 && lat_a <= 30410) ? 1 : 0, 1);
        check("a_valid_cycles", vld_cnt[0], 1);

        send(2, 16, 8, 9'h03, 2, 1, 1, 2'b11, 1);
        send(2, 16, 8, 9'h03, 2, 0, 1, 2'b11, 1);
        send(2, 16, 8, 9'hA7, 2, 0, 1, 2'b11, 1);

        send(3, 16, 7, 9'h41, 0, 0, 2, 2'b11, 1);
        send(3, 16, 7, 9'h41, 0, 0, 2, 2'b01, 1);
        send(3, 16, 7, 9'h2A, 0, 0, 2, 2'b10, 1);

        rdy[1] = 1'b0;
        send(1, 16, 8, 9'h12, 0, 0, 1, 2'b11, 1);
        send(1, 16, 8, 9'hFA, 0, 0, 1, 2'b11, 0);
        exp_ovr[1]++;
        wait_clk(4);
        check("b_hold_valid", vld[1], 1);
        check("b_hold_byte", rbyte[1], 9'h012);
        check("b_overrun_pulse", ovr_cnt[1], 1);
        rdy[1] = 1'b1;
        wait_clk(2);
        check("b_valid_drop", vld[1], 0);

        send(1, 16, 8, 9'h00, 0, 0, 1, 2'b00, 1);
        rx[1] = 1'b0;
        wait_clk(5);
        rx[1] = 1'b1;
        wait_clk(40);
        repeat (8) send(1, 16, 8, 9'($urandom_range(1, 255)), 0, 0, 1, 2'b11, 1);
        send(1, 16, 8, 9'hFA, 0, 0, 1, 2'b00, 1);
        wait_clk(4);

        rx[1] = 1'b0;
        wait_clk(16);
        for (int i = 0; i < 4; i++) begin
            rx[1] = i[0] ? 1'b0 : 1'b1;
            wait_clk(16);
        end
        rx[1] = 1'b1;
        wait_clk(8);
        rst = 1'b0;
        #2;
        check("b_reset_out", {vld[1], ovr[1], fe[1], pe[1], rbyte[1]}, 0);
        wait_clk(3);
        rst = 1'b1;
        wait_clk(20);
        send(1, 16, 8, 9'hA5, 0, 0, 1, 2'b11, 1);

        wait_clk(50);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("d%0d_words_left", d), exp_q[d].size(), 0);
            check($sformatf("d%0d_overruns", d), ovr_cnt[d], exp_ovr[d]);
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
